fast_fifo_multi_channel: RTL and testbench

// - CHANNELS independent FIFOs sharing one memory array, indexed {channel, addr}. Successor to the single-channel fast FIFO.
// - Feeds several producer streams into one consumer-side arbiter.
// - Per cycle: at most one write (any channel) and one read (any channel).
// - Adds full/almostFull per channel, sticky overflow per channel, and a configurable read pipeline.

---
 rtl/fast_fifo_multi_channel.sv | 118 +++++++++++
 tb/tb_fast_fifo_multi_channel.sv | 229 ++++++++++++++++++++++
 2 files changed

// File: rtl/fast_fifo_multi_channel.sv
// Purpose:      CHANNELS independent FIFOs in one shared memory, addressed by {channel, ptr}.
// Latency:      a read accepted at edge E0 presents data in the cycle after edge E0+READ_LATENCY-1.
// Backpressure: none; writes to a full channel are dropped (sticky overflow), reads of an empty channel ignored.
// Ports: clk/rst (async active-low); write side writeEnable/writeChannel/dataIn;
//        read side readRequest/readChannel -> dataOut/dataOutValid/dataOutChannel;
//        per-channel status usedw (packed, DEPTH_LOG2+1 bits per channel), empty, full, almostFull, overflow.
module fast_fifo_multi_channel #(
  parameter int WIDTH              = 20,
  parameter int DEPTH_LOG2         = 5,
  parameter int CHANNEL_BITS       = 2,
  parameter int ALMOST_FULL_MARGIN = 4,
  parameter int READ_LATENCY       = 1
) (
  input  logic                                           clk,
  input  logic                                           rst,
  input  logic                                           writeEnable,
  input  logic [CHANNEL_BITS-1:0]                        writeChannel,
  input  logic [WIDTH-1:0]                               dataIn,
  input  logic                                           readRequest,
  input  logic [CHANNEL_BITS-1:0]                        readChannel,
  output logic [WIDTH-1:0]                               dataOut,
  output logic                                           dataOutValid,
  output logic [CHANNEL_BITS-1:0]                        dataOutChannel,
  output logic [(2**CHANNEL_BITS)*(DEPTH_LOG2+1)-1:0]    usedw,
  output logic [(2**CHANNEL_BITS)-1:0]                   empty,
  output logic [(2**CHANNEL_BITS)-1:0]                   full,
  output logic [(2**CHANNEL_BITS)-1:0]                   almostFull,
  output logic [(2**CHANNEL_BITS)-1:0]                   overflow
);

  localparam int DEPTH    = 2 ** DEPTH_LOG2;
  localparam int CHANNELS = 2 ** CHANNEL_BITS;
  localparam int PW       = DEPTH_LOG2 + 1;
  localparam int AW       = CHANNEL_BITS + DEPTH_LOG2;

  localparam logic [PW-1:0] DEPTH_COUNT = PW'(DEPTH);
  localparam logic [PW-1:0] AF_THRESH   = PW'(DEPTH - ALMOST_FULL_MARGIN);

  // Pointers carry one extra bit so full (diff == DEPTH) and empty (diff == 0) differ.
  logic [PW-1:0]    writePtr [CHANNELS];
  logic [PW-1:0]    readPtr  [CHANNELS];
  logic [PW-1:0]    chUsed   [CHANNELS];
  logic [WIDTH-1:0] mem      [CHANNELS*DEPTH];

  logic             writeAccept;
  logic             readAccept;
  logic [AW-1:0]    writeAddr;
  logic [AW-1:0]    readAddr;

  logic                    pipeVld [READ_LATENCY];
  logic [WIDTH-1:0]        pipeDat [READ_LATENCY];
  logic [CHANNEL_BITS-1:0] pipeCh  [READ_LATENCY];

  // Status is derived only from registered pointers, so no input reaches these outputs combinationally.
  for (genvar c = 0; c < CHANNELS; c++) begin : gStatus
    assign chUsed[c]           = writePtr[c] - readPtr[c];
    assign usedw[c*PW +: PW]   = chUsed[c];
    assign empty[c]            = (chUsed[c] == '0);
    assign full[c]             = (chUsed[c] == DEPTH_COUNT);
    assign almostFull[c]       = (chUsed[c] >= AF_THRESH);
  end

  // Accept decisions use pre-edge status only: a same-cycle read never frees room for a
  // write to a full channel, and a same-cycle write never feeds a read of an empty one.
  assign writeAccept = writeEnable && !full[writeChannel];
  assign readAccept  = readRequest && !empty[readChannel];
  assign writeAddr   = {writeChannel, writePtr[writeChannel][DEPTH_LOG2-1:0]};
  assign readAddr    = {readChannel, readPtr[readChannel][DEPTH_LOG2-1:0]};

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      for (int c = 0; c < CHANNELS; c++) begin
        writePtr[c] <= '0;
        readPtr[c]  <= '0;
      end
      overflow <= '0;
    end else begin
      if (writeAccept) writePtr[writeChannel] <= writePtr[writeChannel] + PW'(1);
      if (readAccept)  readPtr[readChannel]   <= readPtr[readChannel] + PW'(1);
      if (writeEnable && full[writeChannel]) overflow[writeChannel] <= 1'b1;
    end
  end

  // Memory contents are not reset; the pointers alone define what is valid.
  always_ff @(posedge clk) begin
    if (writeAccept) mem[writeAddr] <= dataIn;
  end

  // Stage 0 captures the memory word; later stages only move data when a valid word
  // arrives, so the last stage (dataOut) holds its value between reads.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      for (int i = 0; i < READ_LATENCY; i++) begin
        pipeVld[i] <= 1'b0;
        pipeDat[i] <= '0;
        pipeCh[i]  <= '0;
      end
    end else begin
      pipeVld[0] <= readAccept;
      if (readAccept) begin
        pipeDat[0] <= mem[readAddr];
        pipeCh[0]  <= readChannel;
      end
      for (int i = 1; i < READ_LATENCY; i++) begin
        pipeVld[i] <= pipeVld[i-1];
        if (pipeVld[i-1]) begin
          pipeDat[i] <= pipeDat[i-1];
          pipeCh[i]  <= pipeCh[i-1];
        end
      end
    end
  end

  assign dataOut        = pipeDat[READ_LATENCY-1];
  assign dataOutValid   = pipeVld[READ_LATENCY-1];
  assign dataOutChannel = pipeCh[READ_LATENCY-1];

endmodule

// File: tb/tb_fast_fifo_multi_channel.sv
// Purpose:      directed checks of fast_fifo_multi_channel (READ_LATENCY 1 and 3 instances).
// Latency:      n/a (bench).
// Backpressure: n/a (bench).
module tb_fast_fifo_multi_channel;

  logic        clk;
  // READ_LATENCY = 1 instance
  logic        rst;
  logic        writeEnable, readRequest;
  logic [1:0]  writeChannel, readChannel;
  logic [19:0] dataIn;
  logic [19:0] dataOut;
  logic        dataOutValid;
  logic [1:0]  dataOutChannel;
  logic [23:0] usedw;
  logic [3:0]  empty, full, almostFull, overflow;
  // READ_LATENCY = 3 instance
  logic        rst3;
  logic        we3, rr3;
  logic [1:0]  wc3, rc3;
  logic [19:0] di3;
  logic [19:0] do3;
  logic        dv3;
  logic [1:0]  dc3;
  logic [23:0] uw3;
  logic [3:0]  em3, fu3, af3, ov3;

  int assertCount = 0;
  int failCount   = 0;

  fast_fifo_multi_channel #(.READ_LATENCY(1)) dut (
    .clk(clk), .rst(rst),
    .writeEnable(writeEnable), .writeChannel(writeChannel), .dataIn(dataIn),
    .readRequest(readRequest), .readChannel(readChannel),
    .dataOut(dataOut), .dataOutValid(dataOutValid), .dataOutChannel(dataOutChannel),
    .usedw(usedw), .empty(empty), .full(full), .almostFull(almostFull), .overflow(overflow)
  );

  fast_fifo_multi_channel #(.READ_LATENCY(3)) dut3 (
    .clk(clk), .rst(rst3),
    .writeEnable(we3), .writeChannel(wc3), .dataIn(di3),
    .readRequest(rr3), .readChannel(rc3),
    .dataOut(do3), .dataOutValid(dv3), .dataOutChannel(dc3),
    .usedw(uw3), .empty(em3), .full(fu3), .almostFull(af3), .overflow(ov3)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic checkEq(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    assertCount++;
    if (obs !== exp) begin
      failCount++;
      $display("FAIL %s: got 0x%0h, expected 0x%0h", tag, obs, exp);
    end
  endtask

  // One clock edge, then settle 1 time unit so sampling and driving stay off the edge.
  task automatic step();
    @(posedge clk);
    #1;
  endtask

  function automatic logic [5:0] used(input int c);
    return usedw[c*6 +: 6];
  endfunction

  int got;
  int pulses;

  initial begin
    rst = 1'b0; rst3 = 1'b0;
    writeEnable = 1'b0; readRequest = 1'b0; writeChannel = '0; readChannel = '0; dataIn = '0;
    we3 = 1'b0; rr3 = 1'b0; wc3 = '0; rc3 = '0; di3 = '0;

    // Reset state, before any clock edge
    #2;
    checkEq("rst_empty", empty, 4'b1111);
    checkEq("rst_full", full, 4'b0000);
    checkEq("rst_afull", almostFull, 4'b0000);
    checkEq("rst_ovf", overflow, 4'b0000);
    checkEq("rst_usedw", usedw, 24'h0);
    checkEq("rst_valid", dataOutValid, 1'b0);
    checkEq("rst_dout", dataOut, 20'h0);
    checkEq("rst3_empty", em3, 4'b1111);
    #1;
    rst = 1'b1; rst3 = 1'b1;

    // Order: three writes to ch2, three back-to-back reads
    writeEnable = 1'b1; writeChannel = 2'd2;
    dataIn = 20'hA; step();
    dataIn = 20'hB; step();
    dataIn = 20'hC; step();
    writeEnable = 1'b0;
    checkEq("ord_used2", used(2), 6'd3);
    checkEq("ord_empty", empty, 4'b1011);
    readRequest = 1'b1; readChannel = 2'd2;
    step();
    checkEq("ord_v0", dataOutValid, 1'b1);
    checkEq("ord_d0", dataOut, 20'hA);
    checkEq("ord_c0", dataOutChannel, 2'd2);
    step();
    checkEq("ord_d1", dataOut, 20'hB);
    step();
    checkEq("ord_d2", dataOut, 20'hC);
    checkEq("ord_v2", dataOutValid, 1'b1);
    readRequest = 1'b0;
    step();
    checkEq("ord_vidle", dataOutValid, 1'b0);
    checkEq("ord_hold", dataOut, 20'hC);
    checkEq("ord_empty_end", empty, 4'b1111);

    // Fill ch1 to full, then overflow
    writeEnable = 1'b1; writeChannel = 2'd1;
    for (int i = 0; i < 32; i++) begin
      dataIn = 20'(i);
      step();
      if (i + 1 == 27) checkEq("fill_af27", almostFull[1], 1'b0);
      if (i + 1 == 28) checkEq("fill_af28", almostFull[1], 1'b1);
      if (i + 1 == 31) checkEq("fill_full31", full[1], 1'b0);
      if (i + 1 == 32) begin
        checkEq("fill_full32", full[1], 1'b1);
        checkEq("fill_used32", used(1), 6'd32);
        checkEq("fill_ovf_pre", overflow, 4'b0000);
      end
    end
    dataIn = 20'h77;
    step();
    checkEq("ovf_flag", overflow, 4'b0010);
    checkEq("ovf_used", used(1), 6'd32);
    // Write to the full channel alongside a read of it: write still dropped
    dataIn = 20'h99; readRequest = 1'b1; readChannel = 2'd1;
    step();
    writeEnable = 1'b0; readRequest = 1'b0;
    checkEq("full_rd_valid", dataOutValid, 1'b1);
    checkEq("full_rd_data", dataOut, 20'h0);
    checkEq("full_rd_chan", dataOutChannel, 2'd1);
    checkEq("full_rd_used", used(1), 6'd31);
    checkEq("full_rd_full", full[1], 1'b0);
    checkEq("full_rd_af", almostFull[1], 1'b1);
    checkEq("ovf_sticky", overflow, 4'b0010);

    // Simultaneous read+write on ch0 at usedw=5
    writeEnable = 1'b1; writeChannel = 2'd0;
    for (int i = 0; i < 5; i++) begin
      dataIn = 20'h100 + 20'(i);
      step();
    end
    checkEq("sim_used5", used(0), 6'd5);
    dataIn = 20'h200; readRequest = 1'b1; readChannel = 2'd0;
    step();
    writeEnable = 1'b0;
    checkEq("sim_used_same", used(0), 6'd5);
    checkEq("sim_data", dataOut, 20'h100);
    for (int i = 1; i <= 5; i++) begin
      step();
      checkEq("sim_drain", dataOut, (i == 5) ? 32'h200 : 32'h100 + 32'(i));
    end
    readRequest = 1'b0;
    checkEq("sim_empty0", empty[0], 1'b1);

    // Read of empty ch3 with a same-cycle write: read ignored
    step();
    writeEnable = 1'b1; writeChannel = 2'd3; dataIn = 20'h333;
    readRequest = 1'b1; readChannel = 2'd3;
    step();
    writeEnable = 1'b0; readRequest = 1'b0;
    checkEq("e3_novalid", dataOutValid, 1'b0);
    checkEq("e3_used", used(3), 6'd1);

    // Wrap: 100 cycles write+read on ch0, plus one trailing read
    got = 0;
    for (int k = 0; k <= 100; k++) begin
      writeEnable = (k < 100); writeChannel = 2'd0; dataIn = 20'(k);
      readRequest = 1'b1; readChannel = 2'd0;
      step();
      if (dataOutValid) begin
        checkEq("wrap_data", dataOut, 32'(got));
        got++;
      end
    end
    writeEnable = 1'b0; readRequest = 1'b0;
    step();
    checkEq("wrap_count", got, 32'd100);
    checkEq("wrap_empty0", empty[0], 1'b1);

    // READ_LATENCY=3: normal latency
    we3 = 1'b1; wc3 = 2'd0; di3 = 20'h123;
    step();
    we3 = 1'b0; rr3 = 1'b1; rc3 = 2'd0;
    step();
    rr3 = 1'b0;
    checkEq("l3_v_e0", dv3, 1'b0);
    step();
    checkEq("l3_v_e1", dv3, 1'b0);
    step();
    checkEq("l3_v_e2", dv3, 1'b1);
    checkEq("l3_data", do3, 20'h123);
    checkEq("l3_chan", dc3, 2'd0);
    step();
    checkEq("l3_v_after", dv3, 1'b0);

    // READ_LATENCY=3: reset one cycle after an accepted read
    we3 = 1'b1; wc3 = 2'd1; di3 = 20'h456;
    step();
    we3 = 1'b0; rr3 = 1'b1; rc3 = 2'd1;
    step();
    rr3 = 1'b0;
    step();
    rst3 = 1'b0;
    #1;
    checkEq("rif_valid", dv3, 1'b0);
    checkEq("rif_empty", em3, 4'b1111);
    checkEq("rif_usedw", uw3, 24'h0);
    checkEq("rif_dout", do3, 20'h0);
    @(negedge clk);
    rst3 = 1'b1;
    pulses = 0;
    for (int i = 0; i < 6; i++) begin
      step();
      if (dv3) pulses++;
    end
    checkEq("rif_nopulse", pulses, 32'd0);

    $display("End of test - %0d assertions evaluated, %0d failures", assertCount, failCount);
    $finish;
  end

endmodule
